store_buffer: RTL and testbench

- Small in-order FIFO of pending stores that sits directly upstream of the data memory write port.
- The CPU posts a store (address, data, size) in one cycle and continues. The buffer drains entries to data memory one per cycle whenever the memory write port is granted.
- It flags loads that hit a pending store word, so the core can stall until the store has drained.

---
 rtl/cpu_mem_pkg.sv | 19 +
 rtl/store_buffer_if.sv | 48 ++++
 rtl/sb_align_check.sv | 22 ++
 rtl/store_buffer.sv | 118 +++++++++++
 tb/tb_store_buffer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared CPU / data-memory definitions: store size codes and the
// pending-store entry layout used by the store buffer.
package cpu_mem_pkg;

  // Store size encoding, shared with data memory and the decoder.
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  // One pending store as held in the buffer.
  typedef struct packed {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Bundle of CPU store/load, data-memory drain and status signals around
// the store buffer. The buffer uses the slave view; the core/memory side
// (or a bench) uses the master view.
interface store_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int PTR_W = $clog2(DEPTH);

  // CPU store side
  logic             st_valid;
  logic [1:0]       st_size;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic [31:0]      st_pc;
  logic             st_ready;
  logic             st_err;
  // Load hazard side
  logic [31:0]      ld_addr;
  logic             ld_valid;
  logic             ld_hazard;
  // Data memory write port
  logic             drain_en;
  logic             mem_wr;
  logic [1:0]       mem_store;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_data;
  logic [31:0]      mem_pc;
  // Status
  logic             empty;
  logic [PTR_W:0]   count;

  modport master (
    output st_valid, st_size, st_addr, st_data, st_pc,
    output ld_addr, ld_valid, drain_en,
    input  st_ready, st_err, ld_hazard,
    input  mem_wr, mem_store, mem_addr, mem_data, mem_pc,
    input  empty, count
  );

  modport slave (
    input  st_valid, st_size, st_addr, st_data, st_pc,
    input  ld_addr, ld_valid, drain_en,
    output st_ready, st_err, ld_hazard,
    output mem_wr, mem_store, mem_addr, mem_data, mem_pc,
    output empty, count
  );

endinterface

// File: rtl/sb_align_check.sv
// Legality check for an offered store: size must be legal and the byte
// address must be naturally aligned for that size.
module sb_align_check
  import cpu_mem_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic       ok
);

  // Decode size against the low address bits.
  always_comb begin
    ok = 1'b0;
    case (size)
      SZ_WORD: ok = (addr_lo == 2'b00);
      SZ_HALF: ok = (addr_lo[0] == 1'b0);
      SZ_BYTE: ok = 1'b1;
      default: ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// In-order FIFO of pending CPU stores feeding the data memory write port.
// Stores drain one per granted cycle; loads to a word with a pending store
// raise ld_hazard so the core can stall until the store has drained.
module store_buffer
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave bus
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  sb_entry_t          entries_r [DEPTH];
  logic [DEPTH-1:0]   valid_r;
  logic [PTR_W-1:0]   head_r;
  logic [PTR_W-1:0]   tail_r;
  logic [PTR_W:0]     count_r;
  logic [PTR_W:0]     count_nxt_s;
  logic               st_err_r;

  logic               full_s;
  logic               empty_s;
  logic               ok_s;
  logic               accept_s;
  logic               push_s;
  logic               reject_s;
  logic               pop_s;
  logic               hit_s;
  sb_entry_t          new_entry_s;
  sb_entry_t          head_entry_s;
  logic               unused_s;

  sb_align_check u_align (
    .size    (bus.st_size),
    .addr_lo (bus.st_addr[1:0]),
    .ok      (ok_s)
  );

  // Occupancy is tracked by count so that wrap never confuses full/empty.
  assign full_s   = (count_r == FULL_CNT);
  assign empty_s  = (count_r == {(PTR_W + 1){1'b0}});
  // A full buffer ignores the offer entirely: no push and no error.
  assign accept_s = bus.st_valid & ~full_s;
  assign push_s   = accept_s & ok_s;
  assign reject_s = accept_s & ~ok_s;
  assign pop_s    = bus.drain_en & ~empty_s;

  assign new_entry_s  = '{size: bus.st_size, addr: bus.st_addr,
                          data: bus.st_data, pc: bus.st_pc};
  assign head_entry_s = entries_r[head_r];

  assign bus.st_ready  = ~full_s;
  assign bus.st_err    = st_err_r;
  assign bus.empty     = empty_s;
  assign bus.count     = count_r;
  assign bus.mem_wr    = pop_s;
  // Head values are always presented so waveforms stay readable when idle.
  assign bus.mem_store = head_entry_s.size;
  assign bus.mem_addr  = head_entry_s.addr;
  assign bus.mem_data  = head_entry_s.data;
  assign bus.mem_pc    = head_entry_s.pc;
  assign bus.ld_hazard = bus.ld_valid & hit_s;

  // Hazards are tracked at word granularity, so the byte offset is ignored.
  assign unused_s = ^bus.ld_addr[1:0];

  // Word-address match against every valid entry, including the one popping.
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_s = hit_s | (valid_r[i] & (entries_r[i].addr[31:2] == bus.ld_addr[31:2]));
    end
  end

  // Next occupancy: simultaneous push and pop leaves count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + (PTR_W + 1)'(1'b1);
      2'b01:   count_nxt_s = count_r - (PTR_W + 1)'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Entry payload write at tail; payloads are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      entries_r[tail_r] <= new_entry_s;
    end
  end

  // Pointers, valid bits, count and the one-cycle reject pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r   <= {PTR_W{1'b0}};
      tail_r   <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W + 1){1'b0}};
      valid_r  <= {DEPTH{1'b0}};
      st_err_r <= 1'b0;
    end else begin
      if (pop_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + PTR_W'(1'b1);
      end
      if (push_s) begin
        valid_r[tail_r] <= 1'b1;
        tail_r          <= tail_r + PTR_W'(1'b1);
      end
      count_r  <= count_nxt_s;
      st_err_r <= reject_s;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer (DEPTH=4): table-driven cycles with
// a store scoreboard, plus hand-written held-output and async-reset checks.
module tb_store_buffer;

  typedef struct {
    logic        st_valid;
    logic [1:0]  st_size;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [31:0] st_pc;
    logic        drain;
    logic        ldv;
    logic [31:0] ld_addr;
    logic        e_ready;
    logic        e_haz;
    logic        e_wr;
    logic        e_err;
    int          e_count;
  } vec_t;

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
  } sb_exp_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;
  vec_t vecs[$];
  sb_exp_t exp_q[$];

  store_buffer_if #(.DEPTH(4)) sb_if ();

  store_buffer #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] d, input logic dr, input logic ldv,
                              input logic [31:0] la, input logic rdy, input logic haz,
                              input logic wr, input logic err, input int cnt);
    vec_t r;
    r.st_valid = v;   r.st_size = sz;  r.st_addr = a;  r.st_data = d;
    r.st_pc    = 32'h0000_8000 ^ a;    r.drain = dr;   r.ldv = ldv;  r.ld_addr = la;
    r.e_ready  = rdy; r.e_haz = haz;   r.e_wr = wr;    r.e_err = err; r.e_count = cnt;
    return r;
  endfunction

  task automatic drive_idle();
    sb_if.st_valid = 1'b0; sb_if.st_size = 2'b00; sb_if.st_addr = 32'h0;
    sb_if.st_data  = 32'h0; sb_if.st_pc = 32'h0; sb_if.drain_en = 1'b0;
    sb_if.ld_valid = 1'b0; sb_if.ld_addr = 32'h0;
  endtask

  // Compare the drain port against the oldest expected store.
  task automatic check_drain();
    sb_exp_t e;
    if (exp_q.size() == 0) begin
      check("drain_without_expected_store", 32'h1, 32'h0);
    end else begin
      e = exp_q.pop_front();
      check("mem_addr", sb_if.mem_addr, e.addr);
      check("mem_data", sb_if.mem_data, e.data);
      check("mem_store", {30'h0, sb_if.mem_store}, {30'h0, e.size});
      check("mem_pc", sb_if.mem_pc, e.pc);
    end
  endtask

  // One cycle: drive just after the edge, check combinational outputs,
  // then check registered results just after the next edge.
  task automatic apply(input vec_t v);
    sb_exp_t e;
    sb_if.st_valid = v.st_valid; sb_if.st_size = v.st_size; sb_if.st_addr = v.st_addr;
    sb_if.st_data  = v.st_data;  sb_if.st_pc   = v.st_pc;   sb_if.drain_en = v.drain;
    sb_if.ld_valid = v.ldv;      sb_if.ld_addr = v.ld_addr;
    #1;
    check("st_ready", {31'h0, sb_if.st_ready}, {31'h0, v.e_ready});
    check("ld_hazard", {31'h0, sb_if.ld_hazard}, {31'h0, v.e_haz});
    check("mem_wr", {31'h0, sb_if.mem_wr}, {31'h0, v.e_wr});
    if (sb_if.mem_wr === 1'b1) check_drain();
    if (v.st_valid && v.e_ready && !v.e_err) begin
      e.size = v.st_size; e.addr = v.st_addr; e.data = v.st_data; e.pc = v.st_pc;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    check("count", {29'h0, sb_if.count}, 32'(v.e_count));
    check("empty", {31'h0, sb_if.empty}, {31'h0, (v.e_count == 0)});
    check("st_err", {31'h0, sb_if.st_err}, {31'h0, v.e_err});
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb_if.ld_valid = 1'b1;
    #1;
    check("rst_count", {29'h0, sb_if.count}, 32'h0);
    check("rst_empty", {31'h0, sb_if.empty}, 32'h1);
    check("rst_ready", {31'h0, sb_if.st_ready}, 32'h1);
    check("rst_mem_wr", {31'h0, sb_if.mem_wr}, 32'h0);
    check("rst_st_err", {31'h0, sb_if.st_err}, 32'h0);
    check("rst_hazard", {31'h0, sb_if.ld_hazard}, 32'h0);
    @(posedge clk); #1;

    //           v     sz     addr          data          dr    ldv   ld_addr       rdy   haz   wr    err   cnt
    // basic push then drain
    vecs.push_back(mk(1'b1, 2'b00, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 0));
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 0));
    // fill to full, fifth store held, then drain with push-while-popping
    vecs.push_back(mk(1'b1, 2'b00, 32'h0000_3000, 32'h1111_1111, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(1'b1, 2'b00, 32'h0000_3004, 32'h2222_2222, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 2));
    vecs.push_back(mk(1'b1, 2'b00, 32'h0000_3008, 32'h3333_3333, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 3));
    vecs.push_back(mk(1'b1, 2'b00, 32'h0000_300C, 32'h4444_4444, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 4));
    vecs.push_back(mk(1'b1, 2'b00, 32'h0000_3010, 32'h5555_5555, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 4));
    vecs.push_back(mk(1'b1, 2'b00, 32'h0000_3010, 32'h5555_5555, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 3));
    vecs.push_back(mk(1'b1, 2'b00, 32'h0000_3010, 32'h5555_5555, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 3));
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 2));
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 1));
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 0));
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 0));
    // rejects: misaligned half, illegal size, misaligned word, then pulse ends
    vecs.push_back(mk(1'b1, 2'b01, 32'h0000_1001, 32'h0000_ABCD, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 0));
    vecs.push_back(mk(1'b1, 2'b11, 32'h0000_1000, 32'h0000_00AA, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 0));
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 2'b00, 32'h0000_1002, 32'h1234_5678, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 0));
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 0));
    // legal halfword and its drain
    vecs.push_back(mk(1'b1, 2'b01, 32'h0000_1002, 32'h0000_ABCD, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 0));
    // hazard: no bypass on the push cycle, word match, other word, ld_valid low,
    // still flagged while popping, clear after drain
    vecs.push_back(mk(1'b1, 2'b10, 32'h0000_2003, 32'h0000_005A, 1'b0, 1'b1, 32'h0000_2000, 1'b1, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_2000, 1'b1, 1'b1, 1'b0, 1'b0, 1));
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_2004, 1'b1, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_2000, 1'b1, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b1, 1'b1, 32'h0000_2001, 1'b1, 1'b1, 1'b1, 1'b0, 0));
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_2000, 1'b1, 1'b0, 1'b0, 1'b0, 0));
    // three pending stores ahead of the async reset sequence
    vecs.push_back(mk(1'b1, 2'b00, 32'h0000_4000, 32'hA0A0_A0A0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(1'b1, 2'b10, 32'h0000_4005, 32'h0000_00B1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 2));
    vecs.push_back(mk(1'b1, 2'b01, 32'h0000_400A, 32'h0000_C2C2, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 3));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    // Idle port still shows the head entry.
    drive_idle();
    #1;
    check("held_mem_wr", {31'h0, sb_if.mem_wr}, 32'h0);
    check("held_mem_addr", sb_if.mem_addr, 32'h0000_4000);
    check("held_mem_data", sb_if.mem_data, 32'hA0A0_A0A0);
    sb_if.drain_en = 1'b1;
    #1;
    check("pre_rst_mem_wr", {31'h0, sb_if.mem_wr}, 32'h1);
    // Asynchronous reset between clock edges with three stores pending.
    reset = 1'b1;
    #1;
    check("async_rst_count", {29'h0, sb_if.count}, 32'h0);
    check("async_rst_empty", {31'h0, sb_if.empty}, 32'h1);
    check("async_rst_mem_wr", {31'h0, sb_if.mem_wr}, 32'h0);
    check("async_rst_ready", {31'h0, sb_if.st_ready}, 32'h1);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    drive_idle();

    // Buffer works normally after the reset.
    apply(mk(1'b1, 2'b00, 32'h0000_5000, 32'h0BAD_F00D, 1'b0, 1'b1, 32'h0000_4000, 1'b1, 1'b0, 1'b0, 1'b0, 1));
    apply(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b1, 1'b1, 32'h0000_4000, 1'b1, 1'b0, 1'b1, 1'b0, 0));
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
